fib_seq_ctrl: RTL
=================

# fib_seq_ctrl

Request/response sequencer for the Fibonacci add-and-shift datapath (prev/current register pair). It accepts an index N on a valid/ready request port and runs the datapath N iterations. It returns F(N) on a valid/ready result port, with optional overflow saturation. It sits between any requester (testbench, host FSM) and the Fibonacci datapath, and serialises one computation at a time.

## Interface
- WIDTH, 32, bit width of the Fibonacci terms and the result
- IDX_W, 7, bit width of the requested index N
- clk  input  1  single clock; all state changes on posedge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_n  input  IDX_W  index N; F(0)=0, F(1)=1
- abort  input  1  synchronous cancel of the computation in flight
- res_valid  output  1  result present
- res_ready  input  1  consumer accepts the result
- res_data  output  WIDTH  F(N), modulo or saturated (see Configuration)
- res_idx  output  IDX_W  echo of the accepted N
- res_ovf  output  1  F(N) exceeded 2^WIDTH-1 (only with the macro; otherwise 0)
- busy  output  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: a, b (WIDTH), cnt (IDX_W), ovf_a, ovf_b.
- IDLE:
  - req_ready = !abort.
  - On req_valid && req_ready: load a=0, b=1, cnt=req_n, res_idx=req_n, ovf_a=ovf_b=0, then go to RUN.
- RUN, each edge:
  - If cnt != 0: a<=b, b<=a+b (WIDTH+1-bit sum; bit WIDTH is the carry), cnt<=cnt-1, ovf_a<=ovf_b, ovf_b<=ovf_b|carry.
  - If cnt == 0: go to DONE.
  - After k iterations, a=F(k) and b=F(k+1).
- DONE:
  - res_valid=1.
  - res_data, res_idx and res_ovf are held stable while res_ready is low.
  - res_valid && res_ready returns to IDLE.
- abort (RUN or DONE): next edge goes to IDLE, the result is discarded and res_valid drops. In IDLE, abort only blocks req_ready.
- abort and res_ready both high in DONE: abort wins. The result counts as not consumed.
- Reset values: state=IDLE, a=0, b=1, cnt=0, ovf flags 0, res_valid=0, req_ready=1, busy=0, res_data=0, res_idx=0, res_ovf=0.
- Reset asserted mid-RUN or mid-DONE: immediate return to the reset values with no result emitted.

## Timing
- Handshake: a transfer occurs on a posedge where valid and ready are both 1. Once raised, res_valid stays high until the transfer or an abort.
- Latency from the request accept edge to res_valid high is N+1 cycles; N=0 gives 1 cycle.
- Back-to-back requests: req_ready rises the cycle after the result handshake, so the minimum period is N+3 cycles per request.
- req_n is sampled only on the accept edge; later changes are ignored.
- Maximum N is 2^IDX_W-1 (127). No out-of-range handling; terms wrap or saturate per Configuration.

## Configuration
- Macro: FIB_SEQ_CTRL_OVF_EN.
- Defined:
  - ovf_a/ovf_b tracking is active.
  - In DONE, res_ovf=ovf_a, and res_data=all-ones when ovf_a=1, otherwise a.
  - The flag is sticky for the whole computation.
- Undefined:
  - The ovf logic is removed and res_ovf is tied to 0.
  - res_data=a, i.e. F(N) mod 2^WIDTH.

## Test plan
- Reset, then N=10 with res_ready=1 -> res_valid 11 cycles after accept, res_data=55, res_idx=10, res_ovf=0.
- N=0, then N=1 -> res_data 0 after 1 cycle, then 1 after 2 cycles. req_ready is low while busy and high again the cycle after each result handshake.
- N=47, WIDTH=32 -> res_data=2971215073, res_ovf=0 in both builds.
- N=48, WIDTH=32:
  - macro defined -> res_data=0xFFFFFFFF, res_ovf=1.
  - macro undefined -> res_data=512559680, res_ovf=0.
- Back-pressure: N=20 with res_ready low for 5 cycles -> res_valid and res_data=6765 held stable. Handshake on the 6th cycle, then IDLE.
- Abort at cycle 3 of an N=30 run -> IDLE next edge, no res_valid. A new request N=5 -> 5.
- Separate case: rst_n low mid-RUN -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/fib_seq_ctrl.sv
// Request/response sequencer driving a Fibonacci add-and-shift pair for N iterations.
// Optional overflow saturation is enabled with the FIB_SEQ_CTRL_OVF_EN macro.
module fib_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [IDX_W-1:0] req_n_i,
  input  logic             abort_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [IDX_W-1:0] res_idx_o,
  output logic             res_ovf_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] cnt_q, idx_q;
  logic             done;

`ifdef FIB_SEQ_CTRL_OVF_EN
  logic             ovf_a_q, ovf_b_q;
  logic [WIDTH:0]   sum;
  assign sum = {1'b0, a_q} + {1'b0, b_q};
`else
  logic [WIDTH-1:0] sum;
  assign sum = a_q + b_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef FIB_SEQ_CTRL_OVF_EN
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && !abort_i) begin
            a_q     <= '0;
            b_q     <= WIDTH'(1);
            cnt_q   <= req_n_i;
            idx_q   <= req_n_i;
`ifdef FIB_SEQ_CTRL_OVF_EN
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
`endif
            state_q <= StRun;
          end
        end
        StRun: begin
          if (abort_i) begin
            state_q <= StIdle;
          end else if (cnt_q != '0) begin
            a_q     <= b_q;
            b_q     <= sum[WIDTH-1:0];
            cnt_q   <= cnt_q - IDX_W'(1);
`ifdef FIB_SEQ_CTRL_OVF_EN
            // Sticky: once a term has wrapped, every later term is invalid too.
            ovf_a_q <= ovf_b_q;
            ovf_b_q <= ovf_b_q | sum[WIDTH];
`endif
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // Abort beats a simultaneous handshake; the result is not consumed.
          if (abort_i || res_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done        = (state_q == StDone);
  assign req_ready_o = (state_q == StIdle) && !abort_i;
  assign res_valid_o = done;
  assign busy_o      = (state_q != StIdle);
  assign res_idx_o   = idx_q;

`ifdef FIB_SEQ_CTRL_OVF_EN
  assign res_ovf_o  = done & ovf_a_q;
  assign res_data_o = !done ? '0 : (ovf_a_q ? '1 : a_q);
`else
  assign res_ovf_o  = 1'b0;
  assign res_data_o = done ? a_q : '0;
`endif

endmodule
